// File: rtl/pipe_scroller.sv
// pipe_scroller: owns the pipe-gap state of the playing scene.
// Scrolls every pipe one column left per scroll tick, respawns off-screen
// pipes on the right with an LFSR-driven gap height, detects bird/pipe and
// bird/ground collisions and counts pipes passed.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   run          high while the scene is PLAYING
//   n_row        terminal rows
//   n_col        terminal columns (informational only)
//   altitude     bird altitude; bird screen row = n_row - altitude
//   gaps         slot k at [24*k +: 24] = {position, max_bnd, min_bnd}
//   collide      sticky collision flag
//   score        pipes passed (saturating)
//   score_pulse  one-cycle pulse per score increment
module pipe_scroller #(
    parameter int unsigned N_PIPE       = 3,
    parameter int unsigned SCROLL_DIV   = 4,
    parameter int unsigned PIPE_SPACING = 20,
    parameter int unsigned GAP_H        = 10,
    parameter int unsigned INIT_POS     = 40,
    parameter int unsigned INIT_MIN     = 10,
    parameter int unsigned BIRD_COL     = 8,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [7:0]            n_row,
    input  logic [7:0]            n_col,
    input  logic [7:0]            altitude,
    output logic [24*N_PIPE-1:0]  gaps,
    output logic                  collide,
    output logic [7:0]            score,
    output logic                  score_pulse
);

    localparam int unsigned      DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
    localparam logic [7:0]       GAP      = 8'(GAP_H);
    localparam logic [7:0]       BCOL     = 8'(BIRD_COL);

    logic [7:0]       r_pos [N_PIPE];
    logic [7:0]       r_min [N_PIPE];
    logic [7:0]       r_max [N_PIPE];
    logic [7:0]       r_lfsr;
    logic [DIV_W-1:0] r_div;
    logic             r_collide;
    logic [7:0]       r_score;
    logic             r_pulse;

    logic              w_active;
    logic              w_tick;
    logic              w_hit;
    logic              w_found;
    logic [N_PIPE-1:0] w_sel;
    logic [7:0]        w_other_max;
    logic [8:0]        w_sum;
    logic [7:0]        w_spawn_pos;
    logic [7:0]        w_cand;
    logic [7:0]        w_spawn_min;
    logic [7:0]        w_row;
    logic [7:0]        w_ncross;
    logic [8:0]        w_score_sum;
    logic [7:0]        w_pos_d [N_PIPE];
    logic [7:0]        w_min_d [N_PIPE];
    logic [7:0]        w_max_d [N_PIPE];
    logic              w_unused_n_col;

    assign w_unused_n_col = ^n_col;

    assign w_active = run && !r_collide;
    assign w_tick   = w_active && (r_div == DIV_LAST);

    // Respawn candidate: only the lowest-index slot sitting at column 0 is
    // replaced per tick; it lands PIPE_SPACING right of the furthest other slot.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_PIPE; k++) begin
            if (!w_found && r_pos[k] == 8'd0) begin
                w_sel[k] = 1'b1;
                w_found  = 1'b1;
            end
        end
        w_other_max = 8'd0;
        for (int k = 0; k < N_PIPE; k++) begin
            if (!w_sel[k] && r_pos[k] > w_other_max) begin
                w_other_max = r_pos[k];
            end
        end
        w_sum       = {1'b0, w_other_max} + 9'(PIPE_SPACING);
        w_spawn_pos = w_sum[8] ? 8'hFF : w_sum[7:0];
        w_cand      = 8'd2 + {2'b00, r_lfsr[5:0]};
        // Keep the whole gap above the ground rows.
        w_spawn_min = (w_cand + GAP > n_row - 8'd2) ? (n_row - 8'd2 - GAP) : w_cand;
    end

    // Collision and pipe-crossing detection from the registered gaps.
    always_comb begin
        w_row    = n_row - altitude;
        w_hit    = (altitude == 8'd0);
        w_ncross = 8'd0;
        for (int k = 0; k < N_PIPE; k++) begin
            if (r_pos[k] <= BCOL && (w_row <= r_min[k] || w_row >= r_max[k])) begin
                w_hit = 1'b1;
            end
            if (BIRD_COL > 0 && r_pos[k] == BCOL) begin
                w_ncross = w_ncross + 8'd1;
            end
        end
        w_score_sum = {1'b0, r_score} + {1'b0, w_ncross};
    end

    always_comb begin
        for (int k = 0; k < N_PIPE; k++) begin
            w_pos_d[k] = r_pos[k];
            w_min_d[k] = r_min[k];
            w_max_d[k] = r_max[k];
            if (w_tick) begin
                if (r_pos[k] != 8'd0) begin
                    w_pos_d[k] = r_pos[k] - 8'd1;
                end else if (w_sel[k]) begin
                    w_pos_d[k] = w_spawn_pos;
                    w_min_d[k] = w_spawn_min;
                    w_max_d[k] = w_spawn_min + GAP;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_PIPE; k++) begin
                r_pos[k] <= 8'(INIT_POS + k * PIPE_SPACING);
                r_min[k] <= 8'(INIT_MIN);
                r_max[k] <= 8'(INIT_MIN + GAP_H);
            end
            r_lfsr    <= LFSR_SEED;
            r_div     <= '0;
            r_collide <= 1'b0;
            r_score   <= 8'd0;
            r_pulse   <= 1'b0;
        end else begin
            for (int k = 0; k < N_PIPE; k++) begin
                r_pos[k] <= w_pos_d[k];
                r_min[k] <= w_min_d[k];
                r_max[k] <= w_max_d[k];
            end
            // Free-running so the gap sequence depends on when play starts.
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            if (w_active && !w_tick) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div <= '0;
            end
            r_collide <= r_collide | (run & w_hit);
            if (w_tick && w_ncross != 8'd0) begin
                r_score <= w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
            end
            r_pulse <= w_tick && (w_ncross != 8'd0);
        end
    end

    always_comb begin
        gaps = '0;
        for (int k = 0; k < N_PIPE; k++) begin
            gaps[24*k +: 24] = {r_pos[k], r_max[k], r_min[k]};
        end
    end

    assign collide     = r_collide;
    assign score       = r_score;
    assign score_pulse = r_pulse;

endmodule
